vga_line_fetch_ctrl: RTL and testbench

- Scheduler between the SDRAM/SRAM frame buffer and the VGA timing generator.
- Prefetches each active display line into a ping-pong line buffer using burst read requests with a request/grant handshake.
- Serves pixels to the VGA RGB input from the buffer, indexed by the timing generator's hx.
- Tracks frame and line position itself, and flags an underflow when a line is not ready in time.

---
 rtl/vga_fetch_pkg.sv | 12 +
 rtl/vga_line_ram.sv | 21 ++
 rtl/vga_line_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared widths, line-fetch FSM states and colour-bar table
package vga_fetch_pkg;
  localparam int H_ACT_DEF = 800;
  localparam int V_ACT_DEF = 600;
  localparam int PIX_W = 24;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} fetch_state_e;
  // index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][PIX_W-1:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };
endpackage

// File: rtl/vga_line_ram.sv
// vga_line_ram: ping-pong line buffer, sync write port, registered 1-cycle read port
module vga_line_ram
  import vga_fetch_pkg::*;
#(
  parameter int DEPTH = 2 * H_ACT_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];
  // write incoming beats and register the pixel read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// vga_line_fetch_ctrl: prefetches display lines into a ping-pong buffer and serves RGB; VGA_TEST_PATTERN_EN adds colour bars
module vga_line_fetch_ctrl
  import vga_fetch_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int BURST = 16,
  parameter int ADDR_W = 20,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_sync,
  input  logic              line_sync,
  input  logic              de,
  input  logic [9:0]        hx,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [PIX_W-1:0]  RGB,
  output logic              busy,
  output logic              underflow
);
  localparam int AW = $clog2(2 * H_ACT);
  localparam int BW = $clog2(BURST);
  localparam int LW = $clog2(V_ACT + 1);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
  logic [9:0] pix_q, pix_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] line_q, line_d, done_q, done_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, pend_q, pend_d;
  logic act_q, act_d, blank_q, blank_d, unf_q, unf_d, de_q;
  logic hold, last, we;
  logic [AW-1:0] waddr, raddr;
  logic [PIX_W-1:0] ram_q;
`ifdef VGA_TEST_PATTERN_EN
  logic pat_q;
  logic [PIX_W-1:0] bar_q;
  logic [9:0] bar;
  assign hold = pattern_sel;
  assign bar = hx / 10'(H_ACT / 8);
  // colour bar for this hx, aligned with the buffer read latency
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pat_q <= 1'b0;
      bar_q <= '0;
    end else begin
      pat_q <= pattern_sel;
      bar_q <= BAR_RGB[bar > 10'd7 ? 3'd7 : bar[2:0]];
    end
  assign RGB = !de_q ? '0 : pat_q ? bar_q : blank_q ? '0 : ram_q;
`else
  assign hold = 1'b0;
  assign RGB = (!de_q || blank_q) ? '0 : ram_q;
`endif
  assign mem_req = state_q == REQ;
  assign mem_addr = addr_q;
  assign busy = state_q != IDLE;
  assign underflow = unf_q;
  assign last = (state_q == DATA || state_q == DRAIN) && mem_rvalid && beat_q == BW'(BURST - 1);
  assign we = state_q == DATA && mem_rvalid;
  assign waddr = (wr_bank_q ? AW'(H_ACT) : AW'(0)) + AW'(pix_q);
  assign raddr = (rd_bank_q ? AW'(H_ACT) : AW'(0)) + AW'(hx);
  vga_line_ram #(.DEPTH(2 * H_ACT)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(mem_rdata), .raddr(raddr), .rdata(ram_q)
  );
  // burst FSM, frame/line bookkeeping; frame_sync overrides everything else
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    base_d = base_q;
    pix_d = pix_q;
    beat_d = beat_q;
    line_d = line_q;
    done_d = done_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    pend_d = pend_q;
    act_d = act_q;
    blank_d = blank_q;
    unf_d = unf_q;
    case (state_q)
      IDLE: if (pend_q && !hold) begin
        state_d = REQ;
        addr_d = base_q;
        pend_d = 1'b0;
      end
      REQ: if (mem_gnt) begin
        state_d = DATA;
        beat_d = '0;
      end
      DATA: if (mem_rvalid) begin
        pix_d = pix_q + 10'd1;
        beat_d = beat_q + 1'b1;
        if (last && pix_q != 10'(H_ACT - 1)) begin
          state_d = REQ;
          addr_d = addr_q + ADDR_W'(BURST);
        end else if (last) begin
          done_d = done_q + 1'b1;
          base_d = base_q + ADDR_W'(H_ACT);
          addr_d = base_q + ADDR_W'(H_ACT);
          wr_bank_d = !wr_bank_q;
          pix_d = '0;
          state_d = pend_q ? REQ : IDLE;
          pend_d = 1'b0;
        end
      end
      DRAIN: if (mem_rvalid) begin
        beat_d = beat_q + 1'b1;
        if (last) begin
          state_d = REQ;
          addr_d = base_q;
        end
      end
    endcase
    if (frame_sync) begin
      base_d = FB_BASE;
      addr_d = FB_BASE;
      pix_d = '0;
      wr_bank_d = 1'b0;
      done_d = '0;
      line_d = '0;
      act_d = 1'b1;
      blank_d = 1'b0;
      pend_d = state_q == IDLE;
      state_d = state_q == IDLE ? IDLE : ((state_q == REQ && !mem_gnt) || last) ? REQ : DRAIN;
      beat_d = state_q == REQ ? '0 : beat_d;
    end else if (line_sync && act_q) begin
      rd_bank_d = line_q[0];
      blank_d = done_d <= line_q;
      unf_d = unf_q | (done_d <= line_q);
      line_d = line_q + 1'b1;
      act_d = line_q != LW'(V_ACT - 1);
      pend_d = pend_d | (line_q != LW'(V_ACT - 1));
    end
  end
  // state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      base_q <= FB_BASE;
      pix_q <= '0;
      beat_q <= '0;
      line_q <= '0;
      done_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      pend_q <= 1'b0;
      act_q <= 1'b0;
      blank_q <= 1'b0;
      unf_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      base_q <= base_d;
      pix_q <= pix_d;
      beat_q <= beat_d;
      line_q <= line_d;
      done_q <= done_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      pend_q <= pend_d;
      act_q <= act_d;
      blank_q <= blank_d;
      unf_q <= unf_d;
      de_q <= de;
    end
endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// tb_vga_line_fetch_ctrl: directed bench with a burst memory model for vga_line_fetch_ctrl
module tb_vga_line_fetch_ctrl;
  logic clk, rst, frame_sync, line_sync, de, mem_req, mem_gnt, mem_rvalid, busy, underflow;
  logic [9:0] hx;
  logic [19:0] mem_addr;
  logic [23:0] mem_rdata, RGB;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel;
`endif
  int n_tests = 0, n_fail = 0;
  int gnt_dly = 0, wait_cnt = 0, beats_left = 0, beat_i = 0, nbursts = 0, drop_err = 0, stab_err = 0;
  bit stall = 0;
  logic [19:0] cur_addr, first_addr;
  logic [19:0] alog [128];

  vga_line_fetch_ctrl dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .line_sync(line_sync), .de(de), .hx(hx),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .RGB(RGB), .busy(busy), .underflow(underflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] pix(input logic [19:0] a);
    return {4'h5, a};
  endfunction

  // memory model: grant after gnt_dly waiting cycles, then 16 beats unless stalled
  initial begin
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      if (beats_left > 0) begin
        if (!stall) begin
          mem_rvalid = 1;
          mem_rdata = pix(cur_addr + 20'(beat_i));
          beat_i++;
          beats_left--;
        end
      end else if (mem_req) begin
        if (wait_cnt > 0 && mem_addr != first_addr) stab_err++;
        if (wait_cnt == 0) first_addr = mem_addr;
        if (wait_cnt >= gnt_dly) begin
          mem_gnt = 1;
          cur_addr = mem_addr;
          beats_left = 16;
          beat_i = 0;
          wait_cnt = 0;
          if (nbursts < 128) alog[nbursts] = mem_addr;
          nbursts++;
        end else wait_cnt++;
      end else if (wait_cnt > 0) begin
        drop_err++;
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_fs();
    frame_sync = 1;
    tick();
    frame_sync = 0;
  endtask

  task automatic pulse_ls();
    line_sync = 1;
    tick();
    line_sync = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    chk(tag, {31'b0, busy}, 0);
  endtask

  task automatic show(input string tag, input logic [9:0] h, input logic [23:0] e);
    de = 1;
    hx = h;
    tick();
    chk(tag, RGB, e);
    de = 0;
  endtask

  initial begin
    int seq_err;
    rst = 1;
    frame_sync = 0;
    line_sync = 0;
    de = 0;
    hx = 0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 0;
`endif
    repeat (2) tick();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rgb", RGB, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unf", underflow, 0);
    rst = 0;
    repeat (2) tick();
    pulse_fs();
    for (int n = 0; n < 100 && !(beats_left > 0 && beat_i >= 5); n++) tick();
    chk("mid_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rgb", RGB, 0);
    tick();
    tick();
    rst = 0;
    repeat (20) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_req", mem_req, 0);
    nbursts = 0;
    pulse_fs();
    wait_idle("l0_fetch");
    chk("l0_bursts", nbursts, 50);
    chk("l0_addr0", alog[0], 0);
    chk("l0_addr1", alog[1], 16);
    chk("l0_addr49", alog[49], 784);
    seq_err = 0;
    for (int i = 0; i < 50; i++) if (alog[i] != 20'(16 * i)) seq_err++;
    chk("l0_addr_seq", seq_err, 0);
    pulse_ls();
    show("l0_px0", 0, pix(0));
    show("l0_px5", 5, pix(5));
    show("l0_px799", 799, pix(799));
    hx = 5;
    tick();
    chk("de_off", RGB, 0);
    wait_idle("l1_fetch");
    pulse_ls();
    show("l1_px3", 3, pix(803));
    wait_idle("l2_fetch");
    chk("no_unf", underflow, 0);
    gnt_dly = 7;
    nbursts = 0;
    drop_err = 0;
    stab_err = 0;
    pulse_fs();
    wait_idle("dly_fetch");
    chk("dly_bursts", nbursts, 50);
    chk("dly_req_drop", drop_err, 0);
    chk("dly_addr_stable", stab_err, 0);
    chk("dly_addr49", alog[49], 784);
    gnt_dly = 0;
    stall = 1;
    nbursts = 0;
    pulse_ls();
    repeat (10) tick();
    chk("l0_ready_unf", underflow, 0);
    pulse_ls();
    tick();
    chk("unf_set", underflow, 1);
    show("unf_px3", 3, 0);
    show("unf_px500", 500, 0);
    stall = 0;
    wait_idle("l1_late");
    chk("late_bursts", nbursts, 100);
    chk("late_l1_last", alog[49], 1584);
    chk("late_l2_first", alog[50], 1600);
    show("unf_px3_after", 3, 0);
    nbursts = 0;
    pulse_ls();
    for (int n = 0; n < 200 && !(nbursts > 0 && beat_i >= 9); n++) tick();
    nbursts = 0;
    pulse_fs();
    wait_idle("fs_drain");
    chk("fs_bursts", nbursts, 50);
    chk("fs_addr0", alog[0], 0);
    chk("fs_addr1", alog[1], 16);
    pulse_ls();
    show("fs_px0", 0, pix(0));
    show("fs_px9", 9, pix(9));
    show("fs_px15", 15, pix(15));
    show("fs_px16", 16, pix(16));
    chk("unf_sticky", underflow, 1);
    wait_idle("fs_l1");
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1;
    nbursts = 0;
    pulse_fs();
    repeat (30) tick();
    chk("pat_nobursts", nbursts, 0);
    chk("pat_noreq", mem_req, 0);
    show("pat_0", 0, 24'hFFFFFF);
    show("pat_100", 100, 24'hFFFF00);
    show("pat_799", 799, 24'h000000);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
